// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: 16x-oversampled UART receiver with a small first-word-fall-through
// receive FIFO.
//
// Optional build macro: UART_RX_MAJORITY_EN. When it is defined, each sample point
// takes a 2-of-3 vote over the ticks MID-1, MID and MID+1, and the decision is
// applied at MID+1. When it is undefined, a single sample is taken at MID.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous, active-low reset
//   baud_tick_i     oversample tick, 1-cycle pulse
//   rx_serial_i     serial line, idle high
//   rx_data_o       FIFO head data (0 while the FIFO is empty)
//   rx_frame_err_o  FIFO head: a stop bit was sampled low
//   rx_parity_err_o FIFO head: parity mismatch
//   rx_break_o      FIFO head: all data bits 0 together with a frame error
//   rx_valid_o      FIFO not empty
//   rx_ready_i      consumer pop request
//   rx_overrun_o    sticky: a word was dropped because the FIFO was full
//   clear_err_i     clears rx_overrun_o
//   rx_busy_o       frame reception in progress (FSM not in IDLE)
//
// Handshake: a word leaves the FIFO on every clk_i edge where rx_valid_o and
// rx_ready_i are both high. rx_valid_o only drops through a pop or a reset, and
// the head fields hold steady while rx_valid_o is high and rx_ready_i is low.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 rx_serial_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_break_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_overrun_o,
  input  logic                 clear_err_i,
  output logic                 rx_busy_o
);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WW  = DATA_BITS + 3;
  localparam int MID = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int SMP = MID + 1;
`else
  localparam int SMP = MID;
`endif
  localparam logic [TW-1:0] SMP_T     = TW'(SMP);
  localparam logic [TW-1:0] LAST_T    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n, ferr, ferr_n, ferr_w;
  logic                 push;
  logic [WW-1:0]        push_word;
  logic [2:0]           sync;
  logic                 rx, samp;

  // Three-stage synchronizer; rx is the last stage.
  always_ff @(posedge clk_i) begin
    if (!rst_i) sync <= 3'b111;
    else        sync <= {sync[1:0], rx_serial_i};
  end
  assign rx = sync[2];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] MIDM1_T = TW'(MID - 1);
  localparam logic [TW-1:0] MID_T   = TW'(MID);
  logic [1:0] hist;  // rx captured at MID-1 (hist[1]) and MID (hist[0])

  always_ff @(posedge clk_i) begin
    if (!rst_i) hist <= '0;
    else if (baud_tick_i && (tick_cnt == MIDM1_T || tick_cnt == MID_T))
      hist <= {hist[0], rx};
  end
  // The current rx is the MID+1 sample, so the vote is available at MID+1.
  assign samp = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);
`else
  assign samp = rx;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    perr_n    = perr;
    ferr_n    = ferr;
    ferr_w    = ferr;
    push      = 1'b0;
    push_word = '0;
    if (baud_tick_i) begin
      tick_n = (tick_cnt == LAST_T) ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          tick_n = '0;
          if (!rx) begin
            // The detecting tick counts as tick 0 of the start bit.
            state_n = START;
            tick_n  = TW'(1);
            bit_n   = '0;
            shreg_n = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end
        end
        START: begin
          if (tick_cnt == SMP_T && samp) begin
            state_n = IDLE;
            tick_n  = '0;
          end else if (tick_cnt == LAST_T) begin
            state_n = DATA;
          end
        end
        DATA: begin
          // Shift in from the top: after DATA_BITS samples the first bit is at bit 0.
          if (tick_cnt == SMP_T) shreg_n = {samp, shreg[DATA_BITS-1:1]};
          if (tick_cnt == LAST_T) begin
            if (bit_cnt == LAST_BIT) begin
              bit_n = '0;
              if (PARITY_MODE != 0) state_n = PARITY;
              else                  state_n = STOP;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick_cnt == SMP_T) perr_n = ((^shreg) ^ samp) != (PARITY_MODE == 2);
          if (tick_cnt == LAST_T) state_n = STOP;
        end
        STOP: begin
          if (tick_cnt == SMP_T) begin
            ferr_w = ferr | ~samp;
            ferr_n = ferr_w;
            // Leave at the final stop bit's sample point so a back-to-back
            // start edge is not missed.
            if (bit_cnt == LAST_STOP) begin
              push      = 1'b1;
              push_word = {(shreg == '0) & ferr_w, perr, ferr_w, shreg};
              state_n   = IDLE;
              tick_n    = '0;
            end
          end else if (tick_cnt == LAST_T) begin
            bit_n = bit_cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          tick_n  = '0;
        end
      endcase
    end
  end

  assign rx_busy_o = (state != IDLE);

  // Receive FIFO: pointers wrap naturally at FIFO_DEPTH (power of 2).
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;
  logic [WW-1:0] head;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rx_valid_o & rx_ready_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_overrun_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overrun outranks a simultaneous clear.
      if (push && full && !pop) rx_overrun_o <= 1'b1;
      else if (clear_err_i)     rx_overrun_o <= 1'b0;
    end
  end

  assign rx_valid_o      = (count != '0);
  // Storage is not reset; hold the head fields at 0 while the FIFO is empty.
  assign head            = rx_valid_o ? mem[rd_ptr] : '0;
  assign rx_data_o       = head[DATA_BITS-1:0];
  assign rx_frame_err_o  = head[DATA_BITS];
  assign rx_parity_err_o = head[DATA_BITS+1];
  assign rx_break_o      = head[DATA_BITS+2];
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: a default 8N1 receiver (u0) and an 8E2 receiver (u1).
// Words are written {break, parity_err, frame_err, data}.
module tb_uart_rx_cfg;
  localparam int OS    = 16;
  localparam int MID   = 7;
  localparam int DEPTH = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int SMP = MID + 1;
`else
  localparam int SMP = MID;
`endif

  // ---------------- clock / reset / baud tick ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baud_tick = 1'b0;
  int   div = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    div       <= (div == 3) ? 0 : div + 1;
    baud_tick <= (div == 2);
  end

  logic ser0 = 1'b1, ser1 = 1'b1;
  logic ready0 = 1'b0, ready1 = 1'b0;
  logic clear0 = 1'b0, clear1 = 1'b0;
  logic [7:0] data0, data1;
  logic ferr0, perr0, brk0, valid0, ovr0, busy0;
  logic ferr1, perr1, brk1, valid1, ovr1, busy1;

  uart_rx_cfg u0 (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(baud_tick), .rx_serial_i(ser0),
    .rx_data_o(data0), .rx_frame_err_o(ferr0), .rx_parity_err_o(perr0),
    .rx_break_o(brk0), .rx_valid_o(valid0), .rx_ready_i(ready0),
    .rx_overrun_o(ovr0), .clear_err_i(clear0), .rx_busy_o(busy0)
  );

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(2),
                .FIFO_DEPTH(4)) u1 (
    .clk_i(clk), .rst_i(rst), .baud_tick_i(baud_tick), .rx_serial_i(ser1),
    .rx_data_o(data1), .rx_frame_err_o(ferr1), .rx_parity_err_o(perr1),
    .rx_break_o(brk1), .rx_valid_o(valid1), .rx_ready_i(ready1),
    .rx_overrun_o(ovr1), .clear_err_i(clear1), .rx_busy_o(busy1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic exp_ovr0 = 1'b0, exp_ovr1 = 1'b0;
  logic [10:0] popped_obs, exp_popped;

  // Reference: what a frame should deliver, from the frame's line contents.
  function automatic logic [10:0] model_word(input int which, input logic [7:0] d,
                                             input logic pbit, input logic [1:0] stop_ok);
    logic fe, pe, br;
    fe = (which == 0) ? !stop_ok[0] : (stop_ok != 2'b11);
    pe = 1'b0;
    if (which == 1) pe = (($countones(d) + int'(pbit)) % 2) != 0;  // even parity
    br = fe && (d == 8'h00);
    return {br, pe, fe, d};
  endfunction

  // ---------------- driver tasks ----------------
  // Hold one line value for one oversample tick; optionally pop on the tick edge.
  task automatic slot(input int which, input logic v, input logic pop);
    if (which == 0) ser0 = v; else ser1 = v;
    do begin @(posedge clk); #1; end while (!baud_tick);
    if (pop) begin
      if (which == 0) begin popped_obs = {brk0, perr0, ferr0, data0}; ready0 = 1'b1; end
      else            begin popped_obs = {brk1, perr1, ferr1, data1}; ready1 = 1'b1; end
    end
    @(posedge clk); #1;
    if (pop) begin ready0 = 1'b0; ready1 = 1'b0; end
  endtask

  // Send one frame and update the model. glitch = slot index (from start bit)
  // to invert, or -1. pop_at_push pops the FIFO on the cycle the word lands.
  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stop_ok, input logic pop_at_push,
                            input int glitch);
    logic [10:0] w;
    int g;
    int nstop;
    w = model_word(which, d, pbit, stop_ok);
    if (which == 0) begin
      if (pop_at_push) exp_popped = exp_q0.pop_front();
      if (exp_q0.size() < DEPTH) exp_q0.push_back(w); else exp_ovr0 = 1'b1;
    end else begin
      if (pop_at_push) exp_popped = exp_q1.pop_front();
      if (exp_q1.size() < DEPTH) exp_q1.push_back(w); else exp_ovr1 = 1'b1;
    end
    slot(which, 1'b1, 1'b0);  // align to the tick grid
    g = 0;
    for (int s = 0; s < OS; s++) begin slot(which, 1'b0 ^ (g == glitch), 1'b0); g++; end
    for (int b = 0; b < 8; b++)
      for (int s = 0; s < OS; s++) begin slot(which, d[b] ^ (g == glitch), 1'b0); g++; end
    if (which == 1)
      for (int s = 0; s < OS; s++) begin slot(which, pbit ^ (g == glitch), 1'b0); g++; end
    nstop = (which == 0) ? 1 : 2;
    for (int k = 0; k < nstop; k++)
      for (int s = 0; s < OS; s++)
        slot(which, stop_ok[k] || (s >= 8),
             pop_at_push && (k == nstop - 1) && (s == SMP));
  endtask

  // Observe the head at a falling edge and pop it if present.
  task automatic pop_word(input int which, output logic v, output logic [10:0] w);
    @(negedge clk);
    if (which == 0) begin v = valid0; w = {brk0, perr0, ferr0, data0}; end
    else            begin v = valid1; w = {brk1, perr1, ferr1, data1}; end
    if (v) begin
      if (which == 0) ready0 = 1'b1; else ready1 = 1'b1;
      @(posedge clk); #1;
      ready0 = 1'b0;
      ready1 = 1'b0;
    end
  endtask

  task automatic reset_models();
    exp_q0.delete();
    exp_q1.delete();
    exp_ovr0 = 1'b0;
    exp_ovr1 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 6;
    if (valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b want=0", valid0); end
    if (busy0 !== 1'b0)  begin bad++; $display("FAIL reset_busy0 got=%b want=0", busy0); end
    if (ovr0 !== 1'b0)   begin bad++; $display("FAIL reset_ovr0 got=%b want=0", ovr0); end
    if ({brk0, perr0, ferr0, data0} !== 11'h0)
      begin bad++; $display("FAIL reset_head0 got=%h want=0", {brk0, perr0, ferr0, data0}); end
    if ({valid1, busy1, ovr1} !== 3'b0)
      begin bad++; $display("FAIL reset_ctl1 got=%b want=000", {valid1, busy1, ovr1}); end
    if ({brk1, perr1, ferr1, data1} !== 11'h0)
      begin bad++; $display("FAIL reset_head1 got=%h want=0", {brk1, perr1, ferr1, data1}); end
    rst = 1'b1;
    reset_models();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic v; logic [10:0] w, e;
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0, -1);
    pop_word(0, v, w);
    e = exp_q0.pop_front();
    total += 3;
    if (v !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", v); end
    if (w !== e) begin bad++; $display("FAIL basic_word got=%h want=%h", w, e); end
    @(negedge clk);
    if (valid0 !== 1'b0) begin bad++; $display("FAIL basic_after_pop got=%b want=0", valid0); end
  endtask

  task automatic test_parity();
    logic v; logic [10:0] w, e;
    logic [1:0] stops [3] = '{2'b11, 2'b11, 2'b01};
    logic [7:0] ds [3]    = '{8'h03, 8'h03, 8'hC3};
    logic       ps [3]    = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_frame(1, ds[i], ps[i], stops[i], 1'b0, -1);
      pop_word(1, v, w);
      e = exp_q1.pop_front();
      total += 2;
      if (v !== 1'b1) begin bad++; $display("FAIL parity_valid[%0d] got=%b want=1", i, v); end
      if (w !== e) begin bad++; $display("FAIL parity_word[%0d] got=%h want=%h", i, w, e); end
    end
  endtask

  task automatic test_frame_break();
    logic v; logic [10:0] w, e;
    logic [7:0] ds [2] = '{8'h00, 8'h55};
    for (int i = 0; i < 2; i++) begin
      send_frame(0, ds[i], 1'b0, 2'b10, 1'b0, -1);
      pop_word(0, v, w);
      e = exp_q0.pop_front();
      total += 1;
      if (w !== e) begin bad++; $display("FAIL break_word[%0d] got=%h want=%h", i, w, e); end
    end
  endtask

  task automatic test_start_glitch();
    logic v; logic [10:0] w, e;
    slot(0, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) slot(0, 1'b0, 1'b0);
    total += 3;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b want=1", busy0); end
    for (int s = 0; s < OS; s++) slot(0, 1'b1, 1'b0);
    @(negedge clk);
    if (busy0 !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", busy0); end
    if (valid0 !== 1'b0) begin bad++; $display("FAIL glitch_no_push got=%b want=0", valid0); end
    send_frame(0, 8'h5A, 1'b0, 2'b11, 1'b0, -1);
    pop_word(0, v, w);
    e = exp_q0.pop_front();
    total += 1;
    if (w !== e || v !== 1'b1) begin bad++; $display("FAIL glitch_next_frame got=%b/%h want=1/%h", v, w, e); end
  endtask

  task automatic test_overrun();
    logic v; logic [10:0] w, e;
    for (int i = 0; i < 5; i++) begin
      send_frame(0, 8'h11 + 8'(i), 1'b0, 2'b11, 1'b0, -1);
      @(negedge clk);
      total += 1;
      if (ovr0 !== exp_ovr0) begin bad++; $display("FAIL overrun_flag[%0d] got=%b want=%b", i, ovr0, exp_ovr0); end
    end
    for (int i = 0; i < 4; i++) begin
      pop_word(0, v, w);
      e = exp_q0.pop_front();
      total += 1;
      if (w !== e || v !== 1'b1) begin bad++; $display("FAIL overrun_pop[%0d] got=%b/%h want=1/%h", i, v, w, e); end
    end
    @(negedge clk);
    total += 2;
    if (valid0 !== 1'b0) begin bad++; $display("FAIL overrun_drained got=%b want=0", valid0); end
    clear0 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0;
    exp_ovr0 = 1'b0;
    if (ovr0 !== exp_ovr0) begin bad++; $display("FAIL overrun_clear got=%b want=%b", ovr0, exp_ovr0); end
  endtask

  task automatic test_push_pop_full();
    logic v; logic [10:0] w, e;
    for (int i = 0; i < 4; i++) send_frame(0, 8'($urandom), 1'b0, 2'b11, 1'b0, -1);
    send_frame(0, 8'($urandom), 1'b0, 2'b11, 1'b1, -1);
    @(negedge clk);
    total += 2;
    if (popped_obs !== exp_popped) begin bad++; $display("FAIL full_pushpop_head got=%h want=%h", popped_obs, exp_popped); end
    if (ovr0 !== exp_ovr0) begin bad++; $display("FAIL full_pushpop_ovr got=%b want=%b", ovr0, exp_ovr0); end
    while (exp_q0.size() > 0) begin
      pop_word(0, v, w);
      e = exp_q0.pop_front();
      total += 1;
      if (w !== e || v !== 1'b1) begin bad++; $display("FAIL full_pushpop_drain got=%b/%h want=1/%h", v, w, e); end
    end
  endtask

  task automatic test_mid_reset();
    logic v; logic [10:0] w, e;
    logic [7:0] d = 8'h3C;
    send_frame(1, 8'($urandom), 1'b0, 2'b11, 1'b0, -1);  // leave a word in u1
    slot(0, 1'b1, 1'b0);
    for (int s = 0; s < OS; s++) slot(0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) for (int s = 0; s < OS; s++) slot(0, d[b], 1'b0);
    for (int s = 0; s < 8; s++) slot(0, d[3], 1'b0);
    total += 4;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b want=1", busy0); end
    rst = 1'b0;
    ser0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    reset_models();
    @(negedge clk);
    if (busy0 !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy0); end
    if (valid0 !== 1'b0) begin bad++; $display("FAIL midreset_valid0 got=%b want=0", valid0); end
    if (valid1 !== 1'b0) begin bad++; $display("FAIL midreset_valid1 got=%b want=0", valid1); end
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b0, -1);
    pop_word(0, v, w);
    e = exp_q0.pop_front();
    total += 1;
    if (w !== e || v !== 1'b1) begin bad++; $display("FAIL midreset_next got=%b/%h want=1/%h", v, w, e); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority_glitch();
    logic v; logic [10:0] w, e;
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b0, OS * 3 + MID);
    pop_word(0, v, w);
    e = exp_q0.pop_front();
    total += 1;
    if (w !== e || v !== 1'b1) begin bad++; $display("FAIL majority_glitch got=%b/%h want=1/%h", v, w, e); end
  endtask
`endif

  task automatic test_back_to_back();
    logic v; logic [10:0] w, e;
    int which, n;
    logic [1:0] st;
    for (int it = 0; it < 5; it++) begin
      which = it % 2;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        st = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        send_frame(which, 8'($urandom), 1'($urandom_range(0, 1)), st, 1'b0, -1);
      end
      for (int k = 0; k < n; k++) begin
        pop_word(which, v, w);
        e = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        total += 1;
        if (w !== e || v !== 1'b1) begin bad++; $display("FAIL b2b[%0d.%0d] got=%b/%h want=1/%h", it, k, v, w, e); end
      end
      @(negedge clk);
      total += 1;
      if ((which == 0 ? valid0 : valid1) !== 1'b0)
        begin bad++; $display("FAIL b2b_empty[%0d] got=1 want=0", it); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_break();
    test_start_glitch();
    test_overrun();
    test_push_pop_full();
    test_mid_reset();
`ifdef UART_RX_MAJORITY_EN
    test_majority_glitch();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
